// File: rtl/expander_driver.sv
// Serial transmitter for a shift-register port expander.
// Sends one word per strobe, MSB first, using generated sclk_o/ncs_o.
module expander_driver #(
  parameter int width    = 48,
  parameter int half_div = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [width-1:0] dat_i,
  input  logic             stb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             sclk_o,
  output logic             ncs_o,
  output logic             sdat_o
);

  localparam int HCW = (half_div > 1) ? $clog2(half_div) : 1;
  localparam int BCW = $clog2(width);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(half_div - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(width - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state_reg;
  logic [width-1:0] shift_reg;
  logic [HCW-1:0]   half_cnt_reg;
  logic [BCW-1:0]   bit_cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             sclk_reg;
  logic             ncs_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sclk_reg     <= 1'b0;
      ncs_reg      <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (stb_i) begin
            shift_reg    <= dat_i;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            sclk_reg     <= 1'b0;
            ncs_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_cnt_reg != HALF_LAST) begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end else begin
            half_cnt_reg <= '0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else begin
              // Data moves only on the falling edge, giving h cycles of setup and hold.
              sclk_reg <= 1'b0;
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= HOLD;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {shift_reg[width-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (half_cnt_reg != HALF_LAST) begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end else begin
            half_cnt_reg <= '0;
            ncs_reg      <= 1'b1;
            state_reg    <= GAP;
          end
        end
        GAP: begin
          if (half_cnt_reg != HALF_LAST) begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end else begin
            half_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign sclk_o = sclk_reg;
  assign ncs_o  = ncs_reg;
  assign sdat_o = shift_reg[width-1];

endmodule
